// File: rtl/ir_queue.sv
// rtl/ir_queue.sv - bus-side instruction FIFO presenting opcode/operand under valid/ack.
// Optional IR_OPERAND_OUT_EN adds a registered tristate operand driver onto busOUT.
module ir_queue #(
  parameter int WIDTH = 16,
  parameter int OPC_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           busIN,
  input  logic                       IR_IN,
  input  logic                       ack,
`ifdef IR_OPERAND_OUT_EN
  input  logic                       IR_OUT,
  output logic [WIDTH-1:0]           busOUT,
`endif
  output logic                       valid,
  output logic [OPC_W-1:0]           opcode,
  output logic [WIDTH-OPC_W-1:0]     operand,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_LAST = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PARTIAL,
    S_FULL
  } occ_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  occ_t             r_state;

  logic             w_pop;
  logic             w_push;
  logic [WIDTH-1:0] w_head;

  assign empty = (r_state == S_EMPTY);
  assign full  = (r_state == S_FULL);
  assign valid = !empty;
  assign count = r_count;
  assign overflow = r_overflow;

  // A pop frees the slot in the same edge, so a full queue still accepts a load.
  assign w_pop  = valid & ack;
  assign w_push = IR_IN & (!full | w_pop);

  assign w_head  = r_mem[r_rd_ptr];
  assign opcode  = empty ? '0 : w_head[WIDTH-1 -: OPC_W];
  assign operand = empty ? '0 : w_head[WIDTH-OPC_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= busIN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_state    <= S_EMPTY;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (IR_IN && !w_push) begin
        r_overflow <= 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + C_ONE;
        case (r_state)
          S_EMPTY:   r_state <= (C_LAST == '0) ? S_FULL : S_PARTIAL;
          S_PARTIAL: r_state <= (r_count == C_LAST) ? S_FULL : S_PARTIAL;
          default:   r_state <= r_state;
        endcase
      end else if (w_pop && !w_push) begin
        r_count <= r_count - C_ONE;
        case (r_state)
          S_FULL:    r_state <= (C_LAST == '0) ? S_EMPTY : S_PARTIAL;
          S_PARTIAL: r_state <= (r_count == C_ONE) ? S_EMPTY : S_PARTIAL;
          default:   r_state <= r_state;
        endcase
      end
    end
  end

`ifdef IR_OPERAND_OUT_EN
  logic             r_bus_en;
  logic [WIDTH-1:0] r_bus_word;

  // Snapshot of the head operand; reading it onto the bus does not consume the entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bus_en   <= 1'b0;
      r_bus_word <= '0;
    end else begin
      r_bus_en   <= IR_OUT;
      r_bus_word <= {{OPC_W{1'b0}}, operand};
    end
  end

  assign busOUT = r_bus_en ? r_bus_word : {WIDTH{1'bz}};
`endif

endmodule

// File: tb/tb_ir_queue.sv
// tb/tb_ir_queue.sv - self-checking bench for ir_queue against a queue-based reference model.
module tb_ir_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] busIN = '0;
  logic        IR_IN = 1'b0;
  logic        ack = 1'b0;
  logic        IR_OUT = 1'b0;
  logic        valid, full, empty, overflow;
  logic [3:0]  opcode;
  logic [11:0] operand;
  logic [2:0]  count;
`ifdef IR_OPERAND_OUT_EN
  logic [15:0] busOUT;
`endif

  ir_queue #(.WIDTH(16), .OPC_W(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .busIN(busIN), .IR_IN(IR_IN), .ack(ack),
`ifdef IR_OPERAND_OUT_EN
    .IR_OUT(IR_OUT), .busOUT(busOUT),
`endif
    .valid(valid), .opcode(opcode), .operand(operand), .full(full),
    .empty(empty), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit checking = 1'b0;
  int max_cnt = 0;

  logic [15:0] mq[$];
  logic [15:0] popped[$];
  bit          m_ovf = 1'b0;
  bit          m_bus_z = 1'b1;
  logic [15:0] m_bus = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO following the push/pop acceptance rules.
  always @(posedge clk) begin
    bit pop, push;
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
      m_bus_z = 1'b1;
    end else begin
      pop  = (mq.size() > 0) && ack;
      push = IR_IN && ((mq.size() < 4) || pop);
      m_bus_z = !IR_OUT;
      m_bus = (mq.size() > 0) ? {4'h0, mq[0][11:0]} : 16'h0000;
      if (IR_IN && !push) m_ovf = 1'b1;
      if (pop) popped.push_back(mq.pop_front());
      if (push) mq.push_back(busIN);
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("valid", {31'b0, valid}, {31'b0, mq.size() > 0});
      chk("empty", {31'b0, empty}, {31'b0, mq.size() == 0});
      chk("full", {31'b0, full}, {31'b0, mq.size() == 4});
      chk("count", {29'b0, count}, mq.size());
      chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
      chk("opcode", {28'b0, opcode}, (mq.size() > 0) ? {28'b0, mq[0][15:12]} : 32'd0);
      chk("operand", {20'b0, operand}, (mq.size() > 0) ? {20'b0, mq[0][11:0]} : 32'd0);
`ifdef IR_OPERAND_OUT_EN
      chk("busOUT", {16'b0, busOUT}, m_bus_z ? {16'b0, 16'hzzzz} : {16'b0, m_bus});
`endif
      if (count > max_cnt) max_cnt = count;
    end
  end

  task automatic cyc(input logic ld, input logic [15:0] w, input logic a, input logic io);
    IR_IN = ld; busIN = w; ack = a; IR_OUT = io;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    checking = 1'b1;
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);

    // Single load
    cyc(1'b1, 16'h3A5C, 1'b0, 1'b0);
    chk("t1_valid", {31'b0, valid}, 32'd1);
    chk("t1_opcode", {28'b0, opcode}, 32'h3);
    chk("t1_operand", {20'b0, operand}, 32'hA5C);
    chk("t1_count", {29'b0, count}, 32'd1);

    // Fill then overflow
    do_reset();
    cyc(1'b1, 16'h1001, 1'b0, 1'b0);
    cyc(1'b1, 16'h2002, 1'b0, 1'b0);
    cyc(1'b1, 16'h3003, 1'b0, 1'b0);
    cyc(1'b1, 16'h4004, 1'b0, 1'b0);
    cyc(1'b1, 16'h5005, 1'b0, 1'b0);
    chk("t2_full", {31'b0, full}, 32'd1);
    chk("t2_count", {29'b0, count}, 32'd4);
    chk("t2_ovf", {31'b0, overflow}, 32'd1);
    popped.delete();
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("t2_npop", popped.size(), 32'd4);
    for (int i = 0; i < 4 && i < popped.size(); i++)
      chk("t2_order", {16'b0, popped[i]}, {16'b0, 16'(16'h1001 * (i + 1))});
    chk("t2_empty", {31'b0, empty}, 32'd1);
    chk("t2_ovf_held", {31'b0, overflow}, 32'd1);

    // Mid-stream reset with load and ack asserted
    cyc(1'b1, 16'hC001, 1'b0, 1'b0);
    cyc(1'b1, 16'hC002, 1'b0, 1'b0);
    cyc(1'b1, 16'hC003, 1'b0, 1'b0);
    chk("t5_pre", {29'b0, count}, 32'd3);
    reset = 1'b1;
    cyc(1'b1, 16'hDEAD, 1'b1, 1'b1);
    reset = 1'b0;
    chk("t5_count", {29'b0, count}, 32'd0);
    chk("t5_valid", {31'b0, valid}, 32'd0);
    chk("t5_ovf", {31'b0, overflow}, 32'd0);
    chk("t5_opc", {16'b0, opcode, operand}, 32'd0);
`ifdef IR_OPERAND_OUT_EN
    chk("t5_bus", {16'b0, busOUT}, {16'b0, 16'hzzzz});
`endif

    // Full + load + ack accepted
    cyc(1'b1, 16'h1001, 1'b0, 1'b0);
    cyc(1'b1, 16'h2002, 1'b0, 1'b0);
    cyc(1'b1, 16'h3003, 1'b0, 1'b0);
    cyc(1'b1, 16'h4004, 1'b0, 1'b0);
    cyc(1'b1, 16'h7777, 1'b1, 1'b0);
    chk("t3_count", {29'b0, count}, 32'd4);
    chk("t3_ovf", {31'b0, overflow}, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("t3_head", {16'b0, opcode, operand}, 32'h7777);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);

    // Streaming push+pop with pointer wrap
    do_reset();
    popped.delete();
    max_cnt = 0;
    cyc(1'b1, 16'd0, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) cyc(1'b1, 16'(i), 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("t4_npop", popped.size(), 32'd10);
    for (int i = 0; i < 10 && i < popped.size(); i++)
      chk("t4_seq", {16'b0, popped[i]}, i);
    chk("t4_maxcnt", max_cnt <= 2, 32'd1);
    chk("t4_ovf", {31'b0, overflow}, 32'd0);
    chk("t4_empty", {31'b0, empty}, 32'd1);

`ifdef IR_OPERAND_OUT_EN
    do_reset();
    cyc(1'b1, 16'hB123, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("t6_bus", {16'b0, busOUT}, 32'h0123);
    chk("t6_count", {29'b0, count}, 32'd1);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("t6_busz", {16'b0, busOUT}, {16'b0, 16'hzzzz});
`endif

    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
